// File: rtl/clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// clock_mode_ctrl
//
// Purpose: user-interface controller for the hour/minute/second timekeeper.
// Three raw push-buttons are synchronised and debounced. Each press drives a
// mode state machine that starts and stops timekeeping, picks the display
// status code and edits hour/minute in shadow registers. An edited value is
// committed to the time counters with a single-cycle load strobe.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-low reset
//   btn_mode    raw mode button (active high, asynchronous)
//   btn_inc     raw increment button (active high, asynchronous)
//   btn_set     raw run/stop/abort button (active high, asynchronous)
//   hour_in     live hour counter value, 0..23
//   minute_in   live minute counter value, 0..59
//   run         timekeeping enable
//   status      display status code (0 time, 2 min edit, 3 hour edit, 6 stop)
//   load_en     one-cycle strobe: counters take hour_out/minute_out
//   hour_out    hour value to load
//   minute_out  minute value to load
//   blank_mask  bit1 blanks hour digits, bit0 blanks minute digits
// -----------------------------------------------------------------------------
module clock_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int TIMEOUT_CYCLES  = 2**24,
    parameter int BLINK_BIT       = 14
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_set,
    input  logic [4:0] hour_in,
    input  logic [5:0] minute_in,
    output logic       run,
    output logic [2:0] status,
    output logic       load_en,
    output logic [4:0] hour_out,
    output logic [5:0] minute_out,
    output logic [1:0] blank_mask
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TO_W = (TIMEOUT_CYCLES  > 2) ? $clog2(TIMEOUT_CYCLES)  : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STOP     = 2'd1,
        ST_SET_HOUR = 2'd2,
        ST_SET_MIN  = 2'd3
    } state_t;

    // Button index: 0 = inc, 1 = mode, 2 = set
    logic [2:0] btn_raw;
    logic [2:0] evt;

    assign btn_raw = {btn_set, btn_mode, btn_inc};

    // -------------------------------------------------------------------------
    // Per-button synchroniser, debouncer and rising-edge event pulse
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic            sync1_q, sync2_q;
            logic            level_q, level_d;
            logic            evt_q, evt_d;
            logic [DB_W-1:0] cnt_q, cnt_d;

            // The level flips only after DEBOUNCE_CYCLES consecutive
            // mismatching samples; a single matching sample restarts the run.
            always_comb begin
                level_d = level_q;
                cnt_d   = '0;
                if (sync2_q != level_q) begin
                    if (cnt_q == DB_LAST) begin
                        level_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                evt_d = level_d & ~level_q;
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                    evt_q   <= 1'b0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                    level_q <= level_d;
                    cnt_q   <= cnt_d;
                    evt_q   <= evt_d;
                end
            end

            assign evt[gi] = evt_q;
        end
    endgenerate

    // Priority set > mode > inc; losers in the same cycle are dropped.
    logic ev_set, ev_mode, ev_inc, ev_any;
    assign ev_set  = evt[2];
    assign ev_mode = evt[1] & ~evt[2];
    assign ev_inc  = evt[0] & ~evt[1] & ~evt[2];
    assign ev_any  = |evt;

    // -------------------------------------------------------------------------
    // State and data registers
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [4:0]       sh_hour_q, sh_hour_d;
    logic [5:0]       sh_min_q, sh_min_d;
    logic [TO_W-1:0]  timer_q, timer_d;
    logic [BLINK_BIT:0] blink_q, blink_d;

    logic             run_q, run_d;
    logic [2:0]       status_q, status_d;
    logic             load_q, load_d;
    logic [4:0]       hour_out_q, hour_out_d;
    logic [5:0]       minute_out_q, minute_out_d;
    logic [1:0]       blank_q, blank_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            sh_hour_q    <= '0;
            sh_min_q     <= '0;
            timer_q      <= '0;
            blink_q      <= '0;
            run_q        <= 1'b1;
            status_q     <= 3'd0;
            load_q       <= 1'b0;
            hour_out_q   <= '0;
            minute_out_q <= '0;
            blank_q      <= '0;
        end else begin
            state_q      <= state_d;
            sh_hour_q    <= sh_hour_d;
            sh_min_q     <= sh_min_d;
            timer_q      <= timer_d;
            blink_q      <= blink_d;
            run_q        <= run_d;
            status_q     <= status_d;
            load_q       <= load_d;
            hour_out_q   <= hour_out_d;
            minute_out_q <= minute_out_d;
            blank_q      <= blank_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and shadow update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sh_hour_d = sh_hour_q;
        sh_min_d  = sh_min_q;
        timer_d   = '0;

        unique case (state_q)
            ST_RUN: begin
                if (ev_set) begin
                    state_d = ST_STOP;
                end else if (ev_mode) begin
                    state_d   = ST_SET_HOUR;
                    sh_hour_d = hour_in;
                    sh_min_d  = minute_in;
                end
            end
            ST_STOP: begin
                if (ev_set) state_d = ST_RUN;
            end
            ST_SET_HOUR: begin
                timer_d = timer_q + 1'b1;
                if (ev_set) begin
                    state_d = ST_RUN;
                end else if (ev_mode) begin
                    state_d = ST_SET_MIN;
                end else if (ev_inc) begin
                    sh_hour_d = (sh_hour_q == 5'd23) ? 5'd0 : sh_hour_q + 5'd1;
                end else if (timer_q == TO_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_SET_MIN: begin
                timer_d = timer_q + 1'b1;
                if (ev_set || ev_mode) begin
                    state_d = ST_RUN;
                end else if (ev_inc) begin
                    sh_min_d = (sh_min_q == 6'd59) ? 6'd0 : sh_min_q + 6'd1;
                end else if (timer_q == TO_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Any accepted press restarts the edit timeout, as does entering
        // a SET state from a different state.
        if (ev_any || (state_d != state_q)) timer_d = '0;
    end

    // -------------------------------------------------------------------------
    // Output decode (registered next to the state)
    // -------------------------------------------------------------------------
    always_comb begin
        blink_d      = blink_q + 1'b1;
        run_d        = (state_d == ST_RUN);
        status_d     = 3'd0;
        blank_d      = 2'b00;
        // Commit happens only on a mode press that leaves SET_MIN.
        load_d       = (state_q == ST_SET_MIN) && ev_mode;
        hour_out_d   = load_d ? sh_hour_q : hour_out_q;
        minute_out_d = load_d ? sh_min_q  : minute_out_q;

        unique case (state_d)
            ST_RUN:      status_d = 3'd0;
            ST_STOP:     status_d = 3'd6;
            ST_SET_HOUR: begin
                status_d   = 3'd3;
                blank_d[1] = blink_d[BLINK_BIT];
            end
            ST_SET_MIN: begin
                status_d   = 3'd2;
                blank_d[0] = blink_d[BLINK_BIT];
            end
            default:     status_d = 3'd0;
        endcase
    end

    assign run        = run_q;
    assign status     = status_q;
    assign load_en    = load_q;
    assign hour_out   = hour_out_q;
    assign minute_out = minute_out_q;
    assign blank_mask = blank_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_mode_ctrl
//
// Directed bench for clock_mode_ctrl with short debounce, timeout and blink
// parameters. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_clock_mode_ctrl;

    logic       clock;
    logic       reset;
    logic       btn_mode, btn_inc, btn_set;
    logic [4:0] hour_in;
    logic [5:0] minute_in;
    logic       run;
    logic [2:0] status;
    logic       load_en;
    logic [4:0] hour_out;
    logic [5:0] minute_out;
    logic [1:0] blank_mask;

    int tests_run;
    int tests_failed;

    // load_en monitor
    int         load_cnt;
    int         load_back2back;
    logic       load_prev;
    logic [4:0] load_hour;
    logic [5:0] load_min;

    clock_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (64),
        .BLINK_BIT      (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_set   (btn_set),
        .hour_in   (hour_in),
        .minute_in (minute_in),
        .run       (run),
        .status    (status),
        .load_en   (load_en),
        .hour_out  (hour_out),
        .minute_out(minute_out),
        .blank_mask(blank_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            load_prev <= 1'b0;
        end else begin
            if (load_en) begin
                load_cnt  <= load_cnt + 1;
                load_hour <= hour_out;
                load_min  <= minute_out;
                if (load_prev) load_back2back <= load_back2back + 1;
            end
            load_prev <= load_en;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, obs);
        end
    endtask

    // Press {set, mode, inc} together, hold 12 cycles, release 12 cycles.
    task automatic press(input logic [2:0] mask);
        @(negedge clock);
        btn_set  = mask[2];
        btn_mode = mask[1];
        btn_inc  = mask[0];
        repeat (12) @(negedge clock);
        btn_set  = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    localparam logic [2:0] P_INC  = 3'b001;
    localparam logic [2:0] P_MODE = 3'b010;
    localparam logic [2:0] P_SET  = 3'b100;

    initial begin
        int load_base;
        int cycles;
        int blink_bad;
        int bm0_bad;
        logic bm1_hist [0:255];

        tests_run      = 0;
        tests_failed   = 0;
        load_cnt       = 0;
        load_back2back = 0;
        load_prev      = 1'b0;
        load_hour      = '0;
        load_min       = '0;
        btn_mode       = 1'b0;
        btn_inc        = 1'b0;
        btn_set        = 1'b0;
        hour_in        = 5'd22;
        minute_in      = 6'd58;
        reset          = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Reset state
        check_eq("reset_run",    run,        1);
        check_eq("reset_status", status,     0);
        check_eq("reset_load",   load_en,    0);
        check_eq("reset_blank",  blank_mask, 0);
        check_eq("reset_hour",   hour_out,   0);

        // inc in RUN does nothing
        press(P_INC);
        check_eq("inc_run_status", status,   0);
        check_eq("inc_run_run",    run,      1);
        check_eq("inc_run_load",   load_cnt, 0);

        // Short mode pulses (3 on, 1 off, 3 on) must not produce an event
        @(negedge clock);
        btn_mode = 1'b1;
        repeat (3) @(negedge clock);
        btn_mode = 1'b0;
        @(negedge clock);
        btn_mode = 1'b1;
        repeat (3) @(negedge clock);
        btn_mode = 1'b0;
        repeat (20) @(negedge clock);
        check_eq("bounce_status", status, 0);

        // Edit flow: 22:58 -> hour +3 = 1, minute +2 = 0
        press(P_MODE);
        check_eq("edit_enter_hour", status, 3);
        check_eq("edit_hour_run",   run,    0);
        repeat (3) press(P_INC);
        check_eq("edit_still_hour", status, 3);
        press(P_MODE);
        check_eq("edit_enter_min",  status, 2);
        repeat (2) press(P_INC);
        check_eq("edit_no_load_yet", load_cnt, 0);
        press(P_MODE);
        check_eq("edit_back_run",   status,     0);
        check_eq("edit_run",        run,        1);
        check_eq("edit_load_count", load_cnt,   1);
        check_eq("edit_load_hour",  load_hour,  1);
        check_eq("edit_load_min",   load_min,   0);
        check_eq("edit_hold_hour",  hour_out,   1);
        check_eq("edit_hold_min",   minute_out, 0);

        // Stop / restart
        load_base = load_cnt;
        press(P_SET);
        check_eq("stop_status", status, 6);
        check_eq("stop_run",    run,    0);
        press(P_SET);
        check_eq("restart_status", status,   0);
        check_eq("restart_run",    run,      1);
        check_eq("stop_no_load",   load_cnt, load_base);

        // Timeout from SET_HOUR: 64 sampled cycles in the state, blinking
        @(negedge clock);
        btn_mode = 1'b1;
        cycles = 0;
        while (status != 3'd3 && cycles < 100) begin
            @(negedge clock);
            cycles++;
        end
        check_eq("to_entered", (status == 3'd3) ? 1 : 0, 1);
        btn_mode = 1'b0;
        cycles    = 0;
        bm0_bad   = 0;
        while (status == 3'd3 && cycles < 200) begin
            bm1_hist[cycles] = blank_mask[1];
            if (blank_mask[0] !== 1'b0) bm0_bad++;
            cycles++;
            @(negedge clock);
        end
        check_eq("to_cycles_in_hour", cycles, 64);
        check_eq("to_back_run",       status, 0);
        check_eq("to_no_load",        load_cnt, load_base);
        check_eq("to_blank_after",    blank_mask, 0);
        check_eq("blink_min_zero",    bm0_bad, 0);
        blink_bad = 0;
        for (int i = 4; i < cycles && i < 256; i++) begin
            if (bm1_hist[i] == bm1_hist[i-4]) blink_bad++;
        end
        check_eq("blink_hour_period", blink_bad, 0);

        // set + mode together in SET_MIN: set wins, abort without load
        press(P_MODE);
        press(P_MODE);
        check_eq("abort_in_min", status, 2);
        press(P_SET | P_MODE);
        check_eq("abort_status", status,   0);
        check_eq("abort_run",    run,      1);
        check_eq("abort_no_load", load_cnt, load_base);

        // Reset during SET_HOUR
        press(P_MODE);
        check_eq("rst_in_hour", status, 3);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_run",    run,        1);
        check_eq("rst_status", status,     0);
        check_eq("rst_load",   load_en,    0);
        check_eq("rst_hour",   hour_out,   0);
        check_eq("rst_min",    minute_out, 0);
        check_eq("rst_blank",  blank_mask, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        check_eq("rst_no_load",      load_cnt, load_base);
        check_eq("load_never_b2b",   load_back2back, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
